// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver.
// Two-flop input synchroniser, mid-bit sampling off a free-running baud
// counter, stop-bit check, and one-cycle valid / framing-error strobes.
// A stop bit sampled low parks the FSM in BREAK until the line returns
// high, so a held-low line never looks like a fresh start bit.
module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int          DIVISOR   = CLK_FREQ / BAUD_RATE;
  localparam int          HALF      = DIVISOR / 2;
  localparam logic [31:0] DIV_LAST  = 32'(DIVISOR - 1);
  localparam logic [31:0] HALF_LAST = 32'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic        rx_meta, rx_s;
  logic [31:0] baud_cnt;
  logic [2:0]  bit_index;
  logic [7:0]  shifter;
  logic        half_hit, full_hit;

  assign half_hit = (baud_cnt == HALF_LAST);
  assign full_hit = (baud_cnt == DIV_LAST);

  // Two-flop synchroniser; idles high so reset never fakes a start bit.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_s    <= rx_meta;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rx_s) state_nxt = START;
      START:   if (half_hit) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (full_hit && bit_index == 3'd7) state_nxt = STOP;
      STOP:    if (full_hit) state_nxt = rx_s ? IDLE : BRK;
      BRK:     if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    rx_busy = (state != IDLE);
  end

  // Datapath: baud counter, bit shifter, registered output strobes.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      baud_cnt     <= '0;
      bit_index    <= '0;
      shifter      <= '0;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      // Counter restarts on every state change and wraps per data bit.
      if (state_nxt != state || state == IDLE || state == BRK || full_hit)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + 32'd1;
      case (state)
        START: if (half_hit && !rx_s) bit_index <= 3'd0;
        DATA: if (full_hit) begin
          shifter <= {rx_s, shifter[7:1]};
          if (bit_index != 3'd7) bit_index <= bit_index + 3'd1;
        end
        STOP: if (full_hit) begin
          if (rx_s) begin
            rx_data  <= shifter;
            rx_valid <= 1'b1;
          end else begin
            rx_frame_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIVISOR=10 / HALF=5. The serial line is
// bit-banged from the bench; a monitor logs every strobe into a queue.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_;
  logic       rx_serial;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  int nvec = 0;
  int nerr = 0;

  int         cyc = 0;
  int         vcnt = 0;
  int         fcnt = 0;
  int         both = 0;
  int         last_v_cyc = 0;
  logic [7:0] rxq[$];

  uart_rx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut (
    .clk(clk), .rst_(rst_), .rx_serial(rx_serial),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_frame_err(rx_frame_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_) begin
      if (rx_valid) begin
        rxq.push_back(rx_data);
        vcnt++;
        last_v_cyc = cyc;
      end
      if (rx_frame_err) fcnt++;
      if (rx_valid && rx_frame_err) both++;
    end
  end

  task automatic clr_mon();
    vcnt = 0; fcnt = 0; both = 0;
    rxq.delete();
  endtask

  task automatic idle(input int n);
    rx_serial = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame starting at the current negedge; stop level/length selectable.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_len);
    rx_serial = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_serial = d[i];
      repeat (10) @(negedge clk);
    end
    rx_serial = stop;
    repeat (stop_len) @(negedge clk);
    rx_serial = 1'b1;
  endtask

  task automatic test_reset();
    rst_ = 1'b0;
    rx_serial = 1'b1;
    #1;
    nvec++;
    if ({rx_data, rx_valid, rx_frame_err, rx_busy} !== 11'h0) begin
      nerr++;
      $display("FAIL reset_outputs: got data=%h v=%b fe=%b busy=%b want 00/0/0/0",
               rx_data, rx_valid, rx_frame_err, rx_busy);
    end
    repeat (3) @(negedge clk);
    rst_ = 1'b1;
    repeat (5) @(negedge clk);
    nvec++;
    if (rx_busy !== 1'b0) begin
      nerr++; $display("FAIL reset_idle_busy: got %b want 0", rx_busy);
    end
  endtask

  task automatic test_single();
    int t0;
    clr_mon();
    t0 = cyc;
    send_frame(8'hA5, 1'b1, 10);
    idle(20);
    nvec++;
    if (vcnt !== 1) begin nerr++; $display("FAIL single_count: got %0d want 1", vcnt); end
    nvec++;
    if (rx_data !== 8'hA5) begin nerr++; $display("FAIL single_data: got %h want a5", rx_data); end
    nvec++;
    if (fcnt !== 0) begin nerr++; $display("FAIL single_ferr: got %0d want 0", fcnt); end
    nvec++;
    if (last_v_cyc - t0 < 95 || last_v_cyc - t0 > 100) begin
      nerr++; $display("FAIL single_latency: got %0d want 95..100", last_v_cyc - t0);
    end
    nvec++;
    if (rx_busy !== 1'b0) begin nerr++; $display("FAIL single_busy: got %b want 0", rx_busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h3C;
    clr_mon();
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1, 10);
    idle(20);
    nvec++;
    if (vcnt !== 3) begin nerr++; $display("FAIL b2b_count: got %0d want 3", vcnt); end
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (rxq.size() <= i || rxq[i] !== exp[i]) begin
        nerr++;
        $display("FAIL b2b_data%0d: got %h want %h", i, (rxq.size() > i) ? rxq[i] : 8'hxx, exp[i]);
      end
    end
    nvec++;
    if (fcnt !== 0) begin nerr++; $display("FAIL b2b_ferr: got %0d want 0", fcnt); end
  endtask

  task automatic test_glitch();
    clr_mon();
    rx_serial = 1'b0;
    repeat (3) @(negedge clk);
    rx_serial = 1'b1;
    @(negedge clk);
    nvec++;
    if (rx_busy !== 1'b1) begin nerr++; $display("FAIL glitch_busy_hi: got %b want 1", rx_busy); end
    repeat (7) @(negedge clk);
    nvec++;
    if (rx_busy !== 1'b0) begin nerr++; $display("FAIL glitch_busy_lo: got %b want 0", rx_busy); end
    idle(10);
    nvec++;
    if (vcnt !== 0 || fcnt !== 0) begin
      nerr++; $display("FAIL glitch_strobe: got v=%0d fe=%0d want 0/0", vcnt, fcnt);
    end
    send_frame(8'h5A, 1'b1, 10);
    idle(20);
    nvec++;
    if (vcnt !== 1 || rx_data !== 8'h5A) begin
      nerr++; $display("FAIL glitch_next: got v=%0d data=%h want 1/5a", vcnt, rx_data);
    end
  endtask

  task automatic test_frame_err();
    clr_mon();
    send_frame(8'h81, 1'b0, 10);
    rx_serial = 1'b0;
    repeat (30) @(negedge clk);
    nvec++;
    if (rx_busy !== 1'b1) begin nerr++; $display("FAIL ferr_busy_break: got %b want 1", rx_busy); end
    nvec++;
    if (fcnt !== 1) begin nerr++; $display("FAIL ferr_count: got %0d want 1", fcnt); end
    nvec++;
    if (vcnt !== 0) begin nerr++; $display("FAIL ferr_valid: got %0d want 0", vcnt); end
    nvec++;
    if (rx_data !== 8'h5A) begin nerr++; $display("FAIL ferr_data_kept: got %h want 5a", rx_data); end
    idle(6);
    nvec++;
    if (rx_busy !== 1'b0) begin nerr++; $display("FAIL ferr_busy_release: got %b want 0", rx_busy); end
    idle(120);
    nvec++;
    if (vcnt !== 0 || fcnt !== 1) begin
      nerr++; $display("FAIL ferr_spurious: got v=%0d fe=%0d want 0/1", vcnt, fcnt);
    end
    send_frame(8'h42, 1'b1, 10);
    idle(20);
    nvec++;
    if (vcnt !== 1 || rx_data !== 8'h42) begin
      nerr++; $display("FAIL ferr_next: got v=%0d data=%h want 1/42", vcnt, rx_data);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'hC3;
    clr_mon();
    rx_serial = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_serial = d[i];
      repeat (10) @(negedge clk);
    end
    rx_serial = d[4];
    repeat (5) @(negedge clk);
    rst_ = 1'b0;
    #1;
    nvec++;
    if ({rx_data, rx_valid, rx_frame_err, rx_busy} !== 11'h0) begin
      nerr++;
      $display("FAIL midreset_outputs: got data=%h v=%b fe=%b busy=%b want 00/0/0/0",
               rx_data, rx_valid, rx_frame_err, rx_busy);
    end
    rx_serial = 1'b1;
    repeat (3) @(negedge clk);
    rst_ = 1'b1;
    idle(120);
    nvec++;
    if (vcnt !== 0 || fcnt !== 0 || rx_data !== 8'h00) begin
      nerr++; $display("FAIL midreset_quiet: got v=%0d fe=%0d data=%h want 0/0/00", vcnt, fcnt, rx_data);
    end
    send_frame(8'hC3, 1'b1, 10);
    idle(20);
    nvec++;
    if (vcnt !== 1 || rx_data !== 8'hC3) begin
      nerr++; $display("FAIL midreset_next: got v=%0d data=%h want 1/c3", vcnt, rx_data);
    end
  endtask

  // Stop bit stretched so the next start falls 5 cycles after the stop sample.
  task automatic test_stop_boundary();
    clr_mon();
    send_frame(8'h96, 1'b1, 13);
    send_frame(8'h69, 1'b1, 10);
    idle(20);
    nvec++;
    if (vcnt !== 2) begin nerr++; $display("FAIL bound_count: got %0d want 2", vcnt); end
    nvec++;
    if (rxq.size() < 2 || rxq[0] !== 8'h96 || rxq[1] !== 8'h69) begin
      nerr++;
      $display("FAIL bound_data: got %h %h want 96 69",
               (rxq.size() > 0) ? rxq[0] : 8'hxx, (rxq.size() > 1) ? rxq[1] : 8'hxx);
    end
    nvec++;
    if (fcnt !== 0) begin nerr++; $display("FAIL bound_ferr: got %0d want 0", fcnt); end
  endtask

  task automatic test_exclusive();
    nvec++;
    if (both !== 0) begin nerr++; $display("FAIL strobe_exclusive: got %0d want 0", both); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_stop_boundary();
    test_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that deserialises an asynchronous 8N1 line into bytes; it is the receive-side peer of `uart_tx` and consumes that block's `tx_serial` output (in loopback or across a link). It synchronises the incoming line, detects and validates the start bit, samples each bit at mid-period, checks the stop bit, and presents each received byte with a one-cycle valid strobe or a framing-error strobe.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 115200: line bit rate.
- Derived localparam `DIVISOR` = `CLK_FREQ/BAUD_RATE`, integer division (434 at the defaults). `HALF` = `DIVISOR/2`. `DIVISOR` ≥ 4 is required.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_`  in  1  reset: asynchronous, active-low.
- `rx_serial`  in  1  asynchronous serial line; idle high.
- `rx_data`  out  8  last correctly framed byte, LSB first on the line.
- `rx_valid`  out  1  one-cycle pulse: `rx_data` updated with a new byte.
- `rx_frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `rx_busy`  out  1  high whenever state ≠ IDLE.

## Operation
- **Input synchronisation:** two-flop synchroniser on `rx_serial`; both flops reset to 1. All logic uses the second-flop output `rx_s` only.
- **Baud counter:** 32-bit `baud_cnt`, cleared on every state change.
- **Shift register:** 8-bit `shifter`; `bit_index` is 3 bits.
- **State machine:** IDLE, START, DATA, STOP, BREAK.
- **IDLE:**
  - `baud_cnt` = 0.
  - If `rx_s` == 0, go to START.
- **START:**
  - Count until `baud_cnt` == `HALF-1`, then sample `rx_s`.
  - If the sample is 0, go to DATA with `bit_index` = 0.
  - If the sample is 1 (glitch or false start), return to IDLE with no output strobe.
- **DATA:**
  - At `baud_cnt` == `DIVISOR-1`, shift the sample in: `shifter` ← {`rx_s`, `shifter[7:1]`}.
  - After the sample with `bit_index` == 7, go to STOP; otherwise increment `bit_index`.
- **STOP:** at `baud_cnt` == `DIVISOR-1`, sample `rx_s`.
  - If 1: `rx_data` ← `shifter`, pulse `rx_valid`, go to IDLE.
  - If 0: pulse `rx_frame_err`, leave `rx_data` unchanged, go to BREAK.
- **BREAK:**
  - Stay until `rx_s` == 1, then go to IDLE.
  - This prevents a held-low line (break) from being decoded as a new start bit.
- **No flow control:** a new `rx_valid` overwrites `rx_data`, and the consumer must take the byte within one frame time. There is no overrun flag.
- `rx_valid` and `rx_frame_err` are never high in the same cycle.
- **Reset (asynchronous, effective mid-frame):**
  - state = IDLE; `baud_cnt`, `bit_index`, `shifter` = 0.
  - `rx_data` = 8'h00; `rx_valid` = 0, `rx_frame_err` = 0, `rx_busy` = 0.
  - Synchroniser flops = 1.
  - A partially received frame is discarded. After reset release, a line already low is treated as a start bit, subject to START validation.

## Timing
- **Synchroniser latency:** 2 `clk` from a `rx_serial` edge to `rx_s`.
- **IDLE→START:** on the first edge where `rx_s` == 0.
- **Start sample:** `HALF` cycles after entering START, which is mid start bit.
- **Data sampling:**
  - Data bit n is sampled `HALF` + (n+1)·`DIVISOR` cycles after entering START.
  - The stop bit is sampled at `HALF` + 9·`DIVISOR`.
- **Output strobes:** `rx_valid` / `rx_frame_err` are registered and go high on the edge that samples the stop bit, for exactly 1 cycle.
- **End-to-end latency:** ≈ `HALF` + 9·`DIVISOR` + 3 cycles from the `rx_serial` falling edge to `rx_valid`.
- **Frame turnaround:** the return to IDLE happens in the same edge as the strobe. A start bit arriving immediately after the stop sample (mid stop bit, still high) is not missed, so back-to-back frames from `uart_tx` are received.
- **Glitch rejection:** a low pulse shorter than about `HALF` cycles is rejected.

## Test plan
Benches use `CLK_FREQ`=1_000_000, `BAUD_RATE`=100_000 (`DIVISOR`=10, `HALF`=5), with `uart_tx` at the same parameters driving `rx_serial`.

- **Single byte:** send 0xA5 → exactly one `rx_valid` pulse, `rx_data`=0xA5, `rx_frame_err` never high, pulse at 95–100 cycles after `tx_start`, `rx_busy` low afterwards.
- **Back-to-back:** send 0x00, 0xFF, 0x3C back-to-back (`tx_start` reasserted as soon as `tx_busy` falls) → three `rx_valid` pulses with `rx_data` 0x00, 0xFF, 0x3C in order, no errors.
- **Glitch:** drive `rx_serial` low for 3 cycles in idle → no strobe, `rx_busy` returns low within 8 cycles, next 0x5A frame received correctly.
- **Framing error:** drive a hand-built frame 0x81 with stop bit 0, then hold low 30 cycles, then high → one `rx_frame_err` pulse, no `rx_valid`, `rx_data` keeps previous value, `rx_busy` high until the line returns high, and no spurious frame; the following 0x42 is received correctly.
- **Reset mid-frame:** assert `rst_` low during data bit 4 of a frame → all outputs at reset values immediately; after release with the line idle, no strobe occurs; the next 0xC3 is received correctly.
- **Stop-sample boundary:** start a new start bit exactly 5 cycles after the previous stop sample → both bytes received, no framing error.
